// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: block-RAM ring buffer between the core byte path and the UART.
// Issues one word at a time while the transmitter is idle, with a fixed gap.
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 65536,
  parameter int GAP       = 1,
  parameter int AF_MARGIN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       tx_busy,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [GW-1:0]     gap_cnt;
  logic              wr_en;
  logic              rd_en;
  logic              send;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(DEPTH - AF_MARGIN));
  assign wr_ready    = !full;
  assign tx_valid    = (state == ST_SEND);

  assign send  = (state == ST_SEND);
  assign wr_en = wr_valid && !full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          state_n = ST_FETCH;
          rd_en   = 1'b1;
        end
      end
      ST_FETCH: state_n = ST_SEND;
      ST_SEND:  state_n = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        if (gap_cnt == GW'(GAP - 1))
          state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n = ST_IDLE;
      rd_en   = 1'b0;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
      gap_cnt  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (send)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !send)
        count <= count + 1'b1;
      else if (!wr_en && send)
        count <= count - 1'b1;
      if (wr_valid && full) overflow <= 1'b1;
      if (state == ST_FETCH) tx_data <= ram_q;
      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors plus scoreboard for uart_tx_fifo
// (DEPTH=8, AF_MARGIN=2, GAP=1).
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 1;
  localparam int AFM   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          tx_busy;
  logic          busy_force;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overflow;

  int            busy_cnt;
  bit            emu = 1'b0;

  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [DW-1:0] sb[$];
  int            tx_cyc[$];

  typedef struct {
    bit            wr;
    logic [DW-1:0] d;
    bit            push;
    int            cnt;
    bit            af;
    bit            fl;
    bit            ovf;
  } vec_t;

  vec_t tbl[9];

  uart_tx_fifo #(
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .GAP(GAP),
    .AF_MARGIN(AFM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .count(count),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Consumer model: goes busy for 6 cycles after each issue strobe.
  always @(posedge clk or posedge rst) begin
    if (rst)                busy_cnt <= 0;
    else if (emu && tx_valid) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = busy_force | (busy_cnt != 0);

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  function automatic vec_t mk(bit wr, logic [DW-1:0] d, bit push,
                              int cnt, bit af, bit fl, bit ovf);
    vec_t v;
    v.wr   = wr;
    v.d    = d;
    v.push = push;
    v.cnt  = cnt;
    v.af   = af;
    v.fl   = fl;
    v.ovf  = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    logic [DW-1:0] e;
    if (!rst && tx_valid) begin
      tx_cyc.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got tx_data=%0h, required no issue",
                 tx_data);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_data: got %0h, required %0h", tx_data, e);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    sb.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    repeat (4) tick();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  initial begin
    int            sent;
    int            guard;
    int            expc;
    bit            acc;
    bit            sv;
    logic [CW-1:0] cb;
    logic [DW-1:0] nxt;

    tbl[0] = mk(1, 8'h10, 1, 1, 0, 0, 0);
    tbl[1] = mk(1, 8'h11, 1, 2, 0, 0, 0);
    tbl[2] = mk(1, 8'h12, 1, 3, 0, 0, 0);
    tbl[3] = mk(1, 8'h13, 1, 4, 0, 0, 0);
    tbl[4] = mk(1, 8'h14, 1, 5, 0, 0, 0);
    tbl[5] = mk(1, 8'h15, 1, 6, 1, 0, 0);
    tbl[6] = mk(1, 8'h16, 1, 7, 1, 0, 0);
    tbl[7] = mk(1, 8'h17, 1, 8, 1, 1, 0);
    tbl[8] = mk(1, 8'h18, 0, 8, 1, 1, 1);

    rst        = 1'b1;
    flush      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    busy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    rst = 1'b0;
    tick();

    // single word latency
    wr(8'h41);
    chk("lat_e0_valid", tx_valid, 0);
    tick();
    chk("lat_e1_valid", tx_valid, 0);
    tick();
    chk("lat_e2_valid", tx_valid, 1);
    chk("lat_e2_data", tx_data, 8'h41);
    drain(50);

    // back-to-back cadence
    tx_cyc.delete();
    wr(8'h42);
    wr(8'h43);
    drain(50);
    chk("cad_n", tx_cyc.size(), 2);
    chk("cad_gap", (tx_cyc.size() == 2) ? tx_cyc[1] - tx_cyc[0] : -1, 4);
    chk("cad_count", count, 0);
    chk("cad_empty", empty, 1);

    // busy stall
    busy_force = 1'b1;
    tx_cyc.delete();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    repeat (8) tick();
    chk("stall_none", tx_cyc.size(), 0);
    chk("stall_count", count, 3);
    emu        = 1'b1;
    busy_force = 1'b0;
    drain(200);
    chk("stall_n", tx_cyc.size(), 3);
    chk("stall_sp1", (tx_cyc.size() == 3) ? tx_cyc[1] - tx_cyc[0] : -1, 9);
    chk("stall_sp2", (tx_cyc.size() == 3) ? tx_cyc[2] - tx_cyc[1] : -1, 9);
    emu = 1'b0;
    repeat (10) tick();

    // full / almost_full / overflow table
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_valid = tbl[i].wr;
      wr_data  = tbl[i].d;
      if (tbl[i].push) sb.push_back(tbl[i].d);
      tick();
      wr_valid = 1'b0;
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_af", i), almost_full, tbl[i].af);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), wr_ready, !tbl[i].fl);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
    end
    tx_cyc.delete();
    busy_force = 1'b0;
    drain(200);
    chk("full_drain_n", tx_cyc.size(), 8);
    chk("full_drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // wrap with simultaneous write and issue
    tx_cyc.delete();
    sent  = 0;
    guard = 0;
    nxt   = 8'h80;
    while (sent < 20 && guard < 500) begin
      wr_valid = 1'b1;
      wr_data  = nxt;
      acc      = wr_ready;
      sv       = tx_valid;
      cb       = count;
      if (acc) sb.push_back(nxt);
      tick();
      expc = int'(cb) + int'(acc) - int'(sv);
      chk("wrap_count", count, expc);
      chk("wrap_max", count <= CW'(DEPTH), 1);
      if (acc) begin
        sent++;
        nxt++;
      end
      guard++;
    end
    wr_valid = 1'b0;
    chk("wrap_sent", sent, 20);
    drain(300);
    chk("wrap_n", tx_cyc.size(), 20);

    // flush while in FETCH with 5 queued
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i));
    busy_force = 1'b0;
    tick();
    chk("pre_flush_ovf", overflow, 1);
    chk("pre_flush_count", count, 5);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    sb.delete();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_valid", tx_valid, 0);
    tx_cyc.delete();
    repeat (6) tick();
    chk("flush_quiet", tx_cyc.size(), 0);
    wr(8'h55);
    drain(50);
    chk("flush_after_n", tx_cyc.size(), 1);

    // asynchronous reset mid-SEND
    wr(8'hA5);
    tick();
    tick();
    chk("pre_rst_send", tx_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    rst_chk("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_empty", empty, 1);
    tx_cyc.delete();
    wr(8'h66);
    drain(50);
    chk("post_rst_n", tx_cyc.size(), 1);
    chk("post_rst_drained", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
